// File: rtl/ex_ctrl_pkg.sv
// Shared types for the execute-stage controller.
// States, branch condition codes, op enable and flag bit positions.
package ex_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_VBUSY,
    ST_MBUSY,
    ST_FLUSH,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_END,
    OP_JUMP,
    OP_MEM,
    OP_VEC,
    OP_SCALAR
  } op_cls_e;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z_SET  = 2'b01;
  localparam logic [1:0] COND_N_SET  = 2'b10;
  localparam logic [1:0] COND_Z_CLR  = 2'b11;

  localparam int EN_ALU_INT = 0;
  localparam int EN_ALU_V   = 1;
  localparam int EN_MEM     = 2;
  localparam int EN_JUMP    = 3;
  localparam int EN_SWAP    = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  // Busy counter preload: the entry cycle already counts as one busy
  // cycle, and the exit happens on the cycle the counter reads zero.
  function automatic logic [3:0] busy_load(input int lat);
    return (lat > 1) ? 4'(lat - 2) : 4'd0;
  endfunction

endpackage

// File: rtl/ex_cond_eval.sv
// Branch condition evaluator: cond_i against registered {N,Z} flags.
// Ports: cond_i, flags_i in; taken_o out. Purely combinational.
module ex_cond_eval
  import ex_ctrl_pkg::*;
(
  input  logic [1:0] cond_i,
  input  logic [1:0] flags_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      COND_ALWAYS: taken_o = 1'b1;
      COND_Z_SET:  taken_o = flags_i[FLAG_Z];
      COND_N_SET:  taken_o = flags_i[FLAG_N];
      COND_Z_CLR:  taken_o = ~flags_i[FLAG_Z];
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage controller: issue handshake, unit occupancy, flags,
// branch/flush and halt. Ports: clk_i, rst_i (sync, active high),
// op_valid_i/op_ready_o/issue_o handshake, op_en_i, op_end_i,
// op_nop_i, cond_i, jump_addr_i, alu_flags_i in; flags_q_o, vbusy_o,
// mbusy_o, branch_o, branch_addr_o, flush_o, halted_o, stall_cnt_o
// out. Define EX_CTRL_STALL_CNT_EN to build the stall counter.
module ex_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int VEC_LAT = 3,
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [4:0]        op_en_i,
  input  logic              op_end_i,
  input  logic              op_nop_i,
  input  logic [1:0]        cond_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [1:0]        alu_flags_i,
  output logic              issue_o,
  output logic [1:0]        flags_q_o,
  output logic              vbusy_o,
  output logic              mbusy_o,
  output logic              branch_o,
  output logic [ADDR_W-1:0] branch_addr_o,
  output logic              flush_o,
  output logic              halted_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [3:0] VEC_LD = busy_load(VEC_LAT);
  localparam logic [3:0] MEM_LD = busy_load(MEM_LAT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        flags_q, flags_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  op_cls_e           op_cls;
  logic              taken;
  logic              ready;
  logic              issue;

  ex_cond_eval u_cond (
    .cond_i  (cond_i),
    .flags_i (flags_q),
    .taken_o (taken)
  );

  // Priority decode; lower-ranked enables are ignored.
  always_comb begin
    op_cls = OP_NONE;
    if (op_end_i)
      op_cls = OP_END;
    else if (op_nop_i)
      op_cls = OP_NONE;
    else if (op_en_i[EN_JUMP])
      op_cls = OP_JUMP;
    else if (op_en_i[EN_MEM])
      op_cls = OP_MEM;
    else if (op_en_i[EN_ALU_V])
      op_cls = OP_VEC;
    else if (op_en_i[EN_ALU_INT] | op_en_i[EN_SWAP])
      op_cls = OP_SCALAR;
  end

  assign ready = (state_q == ST_RUN);
  assign issue = op_valid_i & ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_RUN: begin
        if (issue) begin
          unique case (op_cls)
            OP_END: state_d = ST_HALT;
            OP_JUMP: begin
              if (taken) begin
                state_d = ST_FLUSH;
                addr_d  = jump_addr_i;
              end
            end
            OP_MEM: begin
              if (MEM_LAT > 1) begin
                state_d = ST_MBUSY;
                cnt_d   = MEM_LD;
              end
            end
            OP_VEC: begin
              if (VEC_LAT > 1) begin
                state_d = ST_VBUSY;
                cnt_d   = VEC_LD;
              end
            end
            OP_SCALAR: begin
              // A scalar swap alone leaves the flags alone.
              if (op_en_i[EN_ALU_INT])
                flags_d = alu_flags_i;
            end
            default: ;
          endcase
        end
      end
      ST_VBUSY, ST_MBUSY: begin
        if (cnt_q == 4'd0)
          state_d = ST_RUN;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      flags_q <= 2'b00;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      addr_q  <= addr_d;
    end
  end

`ifdef EX_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (op_valid_i && !ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_q <= 16'd0;
    else
      stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

  assign op_ready_o    = ready;
  assign issue_o       = issue;
  assign flags_q_o     = flags_q;
  assign vbusy_o       = (state_q == ST_VBUSY);
  assign mbusy_o       = (state_q == ST_MBUSY);
  assign branch_o      = (state_q == ST_FLUSH);
  assign flush_o       = (state_q == ST_FLUSH);
  assign branch_addr_o = addr_q;
  assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_ex_ctrl.sv
// Self-checking bench for ex_ctrl with a cycle-level reference model.
// Directed scenarios first, then randomized traffic.
module tb_ex_ctrl;

  localparam int VL = 3;
  localparam int ML = 4;
  localparam int AW = 10;
`ifdef EX_CTRL_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          op_valid_i;
  logic          op_ready_o;
  logic [4:0]    op_en_i;
  logic          op_end_i;
  logic          op_nop_i;
  logic [1:0]    cond_i;
  logic [AW-1:0] jump_addr_i;
  logic [1:0]    alu_flags_i;
  logic          issue_o;
  logic [1:0]    flags_q_o;
  logic          vbusy_o;
  logic          mbusy_o;
  logic          branch_o;
  logic [AW-1:0] branch_addr_o;
  logic          flush_o;
  logic          halted_o;
  logic [15:0]   stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ex_ctrl #(.VEC_LAT(VL), .MEM_LAT(ML), .ADDR_W(AW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .op_en_i       (op_en_i),
    .op_end_i      (op_end_i),
    .op_nop_i      (op_nop_i),
    .cond_i        (cond_i),
    .jump_addr_i   (jump_addr_i),
    .alu_flags_i   (alu_flags_i),
    .issue_o       (issue_o),
    .flags_q_o     (flags_q_o),
    .vbusy_o       (vbusy_o),
    .mbusy_o       (mbusy_o),
    .branch_o      (branch_o),
    .branch_addr_o (branch_addr_o),
    .flush_o       (flush_o),
    .halted_o      (halted_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Reference model: remaining busy cycles, pending flush, halt flag.
  int            m_left = 0;
  bit            m_isv = 1'b0;
  bit            m_halt = 1'b0;
  bit            m_flush = 1'b0;
  logic [1:0]    m_flags = 2'b00;
  logic [AW-1:0] m_addr = '0;
  int            m_stall = 0;

  function automatic bit m_ready();
    return !m_halt && m_left == 0 && !m_flush;
  endfunction

  function automatic bit m_taken(input logic [1:0] c);
    case (c)
      2'd0:    return 1'b1;
      2'd1:    return m_flags[0];
      2'd2:    return m_flags[1];
      default: return !m_flags[0];
    endcase
  endfunction

  task automatic m_step();
    bit rdy;
    rdy = m_ready();
    if (rst_i) begin
      m_left = 0; m_halt = 0; m_flush = 0;
      m_flags = 2'b00; m_addr = '0; m_stall = 0;
      return;
    end
    if (STALL_EN && op_valid_i && !rdy && m_stall < 65535)
      m_stall++;
    if (m_flush)
      m_flush = 0;
    else if (m_left > 0)
      m_left--;
    else if (!m_halt && op_valid_i) begin
      if (op_end_i) m_halt = 1;
      else if (op_nop_i) ;
      else if (op_en_i[3]) begin
        if (m_taken(cond_i)) begin
          m_flush = 1;
          m_addr = jump_addr_i;
        end
      end
      else if (op_en_i[2]) begin m_left = ML - 1; m_isv = 0; end
      else if (op_en_i[1]) begin m_left = VL - 1; m_isv = 1; end
      else if (op_en_i[0]) m_flags = alu_flags_i;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    m_step();
    #1;
  endtask

  task automatic idle();
    rst_i = 0; op_valid_i = 0; op_en_i = 0; op_end_i = 0;
    op_nop_i = 0; cond_i = 0; jump_addr_i = 0; alu_flags_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    tick(); tick();
    n_vec++;
    if (flags_q_o !== 2'b00) begin
      n_err++; $display("FAIL rst_flags got %b exp 00", flags_q_o);
    end
    n_vec++;
    if ({vbusy_o, mbusy_o, branch_o, flush_o, halted_o} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_status got %b exp 00000",
               {vbusy_o, mbusy_o, branch_o, flush_o, halted_o});
    end
    n_vec++;
    if (branch_addr_o !== '0 || stall_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL rst_regs addr %h stall %0d exp 0/0",
               branch_addr_o, stall_cnt_o);
    end
    rst_i = 0;
    #1;
    n_vec++;
    if (op_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_ready got %b exp 1", op_ready_o);
    end
  endtask

  task automatic test_alu_int();
    op_valid_i = 1; op_en_i = 5'b00001; alu_flags_i = 2'b01;
    #1;
    n_vec++;
    if (issue_o !== 1'b1) begin
      n_err++; $display("FAIL alu_issue got %b exp 1", issue_o);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (flags_q_o !== 2'b01 || op_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL alu_flags got %b/%b exp 01/1", flags_q_o, op_ready_o);
    end
  endtask

  task automatic test_vec();
    op_valid_i = 1; op_en_i = 5'b10010;
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_vec++;
      if (vbusy_o !== (c < 3) || op_ready_o !== (c == 3)) begin
        n_err++;
        $display("FAIL vec_c%0d vbusy %b ready %b exp %b %b", c,
                 vbusy_o, op_ready_o, c < 3, c == 3);
      end
      if (c < 3) tick();
    end
  endtask

  task automatic test_branch();
    op_valid_i = 1; op_en_i = 5'b01000; cond_i = 2'b01;
    jump_addr_i = 10'h155;
    tick();
    idle();
    n_vec++;
    if (branch_o !== 1 || flush_o !== 1 || branch_addr_o !== 10'h155) begin
      n_err++;
      $display("FAIL br_take b %b f %b a %h exp 1 1 155",
               branch_o, flush_o, branch_addr_o);
    end
    tick();
    n_vec++;
    if (branch_o !== 0 || flush_o !== 0 || op_ready_o !== 1) begin
      n_err++;
      $display("FAIL br_end b %b f %b r %b exp 0 0 1",
               branch_o, flush_o, op_ready_o);
    end
    op_valid_i = 1; op_en_i = 5'b01000; cond_i = 2'b10;
    jump_addr_i = 10'h0AA;
    tick();
    idle();
    n_vec++;
    if (branch_o !== 0 || branch_addr_o !== 10'h155) begin
      n_err++;
      $display("FAIL br_not b %b a %h exp 0 155", branch_o, branch_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    op_valid_i = 1; op_en_i = 5'b00001; alu_flags_i = 2'b10;
    tick();
    op_en_i = 5'b01000; cond_i = 2'b10; jump_addr_i = 10'h02A;
    tick();
    idle();
    n_vec++;
    if (branch_o !== 1 || branch_addr_o !== 10'h02A) begin
      n_err++;
      $display("FAIL b2b_n b %b a %h exp 1 02a", branch_o, branch_addr_o);
    end
    tick();
    op_valid_i = 1; op_en_i = 5'b00001; alu_flags_i = 2'b01;
    tick();
    op_en_i = 5'b01000; cond_i = 2'b11; jump_addr_i = 10'h3FF;
    tick();
    idle();
    n_vec++;
    if (branch_o !== 0 || branch_addr_o !== 10'h02A) begin
      n_err++;
      $display("FAIL b2b_z b %b a %h exp 0 02a", branch_o, branch_addr_o);
    end
  endtask

  task automatic test_mem_stall();
    rst_i = 1;
    tick();
    rst_i = 0; op_valid_i = 1; op_en_i = 5'b00100;
    tick();
    op_en_i = 5'b00000; op_nop_i = 1;
    for (int c = 1; c <= 3; c++) begin
      n_vec++;
      if (mbusy_o !== 1 || op_ready_o !== 0) begin
        n_err++;
        $display("FAIL mem_c%0d mbusy %b ready %b exp 1 0",
                 c, mbusy_o, op_ready_o);
      end
      tick();
    end
    n_vec++;
    if (mbusy_o !== 0 || stall_cnt_o !== (STALL_EN ? 16'd3 : 16'd0)) begin
      n_err++;
      $display("FAIL mem_stall mbusy %b stall %0d exp 0 %0d",
               mbusy_o, stall_cnt_o, STALL_EN ? 3 : 0);
    end
    idle();
  endtask

  task automatic test_halt();
    op_valid_i = 1; op_en_i = 5'b11111; op_end_i = 1;
    tick();
    op_end_i = 0; op_en_i = 5'b00001; alu_flags_i = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (halted_o !== 1 || op_ready_o !== 0 || issue_o !== 0 ||
          flags_q_o !== m_flags) begin
        n_err++;
        $display("FAIL halt_c%0d h %b r %b i %b fl %b exp 1 0 0 %b", c,
                 halted_o, op_ready_o, issue_o, flags_q_o, m_flags);
      end
      tick();
    end
    idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    n_vec++;
    if (halted_o !== 0 || op_ready_o !== 1) begin
      n_err++;
      $display("FAIL halt_rst h %b r %b exp 0 1", halted_o, op_ready_o);
    end
  endtask

  task automatic test_reset_mid_vbusy();
    op_valid_i = 1; op_en_i = 5'b00001; alu_flags_i = 2'b01;
    tick();
    op_en_i = 5'b00010;
    tick();
    idle();
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    n_vec++;
    if (vbusy_o !== 0 || op_ready_o !== 1 || flags_q_o !== 2'b00) begin
      n_err++;
      $display("FAIL rst_vbusy v %b r %b fl %b exp 0 1 00",
               vbusy_o, op_ready_o, flags_q_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst_i       = ($urandom_range(0, 59) == 0);
      op_valid_i  = ($urandom_range(0, 9) < 7);
      op_en_i     = 5'($urandom);
      op_end_i    = ($urandom_range(0, 29) == 0);
      op_nop_i    = ($urandom_range(0, 7) == 0);
      cond_i      = 2'($urandom);
      jump_addr_i = AW'($urandom);
      alu_flags_i = 2'($urandom);
      #1;
      n_vec++;
      if (op_ready_o !== m_ready() ||
          issue_o !== (op_valid_i & m_ready())) begin
        n_err++;
        $display("FAIL rnd_hs cyc %0d r %b i %b exp %b %b", i,
                 op_ready_o, issue_o, m_ready(), op_valid_i & m_ready());
      end
      tick();
      n_vec++;
      if (flags_q_o !== m_flags || branch_addr_o !== m_addr ||
          stall_cnt_o !== 16'(m_stall)) begin
        n_err++;
        $display("FAIL rnd_regs cyc %0d fl %b a %h s %0d exp %b %h %0d",
                 i, flags_q_o, branch_addr_o, stall_cnt_o,
                 m_flags, m_addr, m_stall);
      end
      n_vec++;
      if (vbusy_o !== (m_left > 0 && m_isv) ||
          mbusy_o !== (m_left > 0 && !m_isv) ||
          branch_o !== m_flush || flush_o !== m_flush ||
          halted_o !== m_halt) begin
        n_err++;
        $display("FAIL rnd_st cyc %0d vmbfh %b%b%b%b%b exp %b%b%b%b%b", i,
                 vbusy_o, mbusy_o, branch_o, flush_o, halted_o,
                 m_left > 0 && m_isv, m_left > 0 && !m_isv,
                 m_flush, m_flush, m_halt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_int();
    test_vec();
    test_branch();
    test_back_to_back();
    test_mem_stall();
    test_halt();
    test_reset_mid_vbusy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_ctrl.md
EX_CTRL -- requirements
Module: ex_ctrl

Interface
REQ-001 Parameter VEC_LAT, default 3: vector ALU/vector swap occupancy in cycles, legal 1..15.
REQ-002 Parameter MEM_LAT, default 2: memory op occupancy in cycles, legal 1..15.
REQ-003 Parameter ADDR_W, default 10: jump address width.
REQ-004 Port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 Port rst_i  in  1  synchronous, active-high reset.
REQ-006 Port op_valid_i  in  1  decoded op present.
REQ-007 Port op_ready_o  out  1  controller accepts op this cycle.
REQ-008 Port op_en_i  in  5  {swap, jump, mem, alu_v, alu_int} unit enables.
REQ-009 Port op_end_i  in  1  end-of-program op; op_nop_i  in  1  no-op.
REQ-010 Port cond_i  in  2  branch condition: 00 always, 01 Z set, 10 N set, 11 Z clear.
REQ-011 Port jump_addr_i  in  ADDR_W  branch target.
REQ-012 Port alu_flags_i  in  2  scalar ALU flags {N,Z} of the op being issued.
REQ-013 Port issue_o  out  1  handshake fire (op_valid_i & op_ready_o).
REQ-014 Port flags_q_o  out  2  registered {N,Z}; vbusy_o  out  1; mbusy_o  out  1.
REQ-015 Port branch_o  out  1  taken-branch pulse; branch_addr_o  out  ADDR_W; flush_o  out  1.
REQ-016 Port halted_o  out  1  end reached; stall_cnt_o  out  16  stall counter.

Function
REQ-017 States RUN, VBUSY, MBUSY, FLUSH, HALT; op_ready_o = 1 only in RUN.
REQ-018 Accepted op decoded by priority: end > nop > jump > mem > alu_v/vector swap > alu_int/scalar swap; lower set enables ignored.
REQ-019 End: next state HALT, halted_o=1; HALT holds until reset, later op_valid_i ignored.
REQ-020 Nop: stay RUN, flags unchanged, no busy.
REQ-021 alu_int or scalar swap: single cycle, stay RUN; alu_int issue loads flags_q_o from alu_flags_i on that edge; swap leaves flags unchanged.
REQ-022 alu_v (or swap with alu_v): VEC_LAT>1 -> VBUSY for VEC_LAT-1 cycles, vbusy_o high throughout, then RUN; VEC_LAT=1 -> stay RUN.
REQ-023 mem: identical rule with MEM_LAT, MBUSY, mbusy_o.
REQ-024 jump: condition evaluated on flags_q_o as registered before the issue edge; taken -> branch_o=1, branch_addr_o=jump_addr_i for the cycle after issue, state FLUSH for exactly that cycle with flush_o=1, then RUN; not taken -> stay RUN, no pulse.
REQ-025 Back-to-back: alu_int in cycle N followed by jump in N+1 evaluates the flags written by N.
REQ-026 Busy counter 4-bit, loaded with latency-2 on entry, decremented each cycle, exit at 0; no wrap.
REQ-027 branch_addr_o holds last taken target when branch_o low.

Reset
REQ-028 rst_i high at a clock edge: state RUN, counter 0, flags_q_o=00, branch_o/flush_o/vbusy_o/mbusy_o/halted_o=0, branch_addr_o=0, stall_cnt_o=0; op_ready_o=1 the cycle after.
REQ-029 Reset mid-VBUSY, MBUSY, FLUSH or HALT aborts immediately to RUN; the in-flight op is not completed.

Configuration
REQ-030 Macro EX_CTRL_STALL_CNT_EN defined: stall_cnt_o increments by 1 each cycle op_valid_i=1 and op_ready_o=0, saturating at 16'hFFFF, cleared only by reset.
REQ-031 Macro undefined: stall_cnt_o tied to 0, no counter flops.

Structure
REQ-032 Package ex_ctrl_pkg holds state enum, cond encodings, op_en bit indices, flag bit indices (Z=0, N=1).
REQ-033 Sub-module ex_cond_eval: combinational cond_i x flags -> taken.

Verification
REQ-034 Reset, then alu_int with alu_flags_i=01 -> flags_q_o=01 next cycle, op_ready_o stays 1.
REQ-035 VEC_LAT=3, alu_v issue at cycle 0 -> vbusy_o=1 and op_ready_o=0 in cycles 1-2, ready in cycle 3.
REQ-036 flags_q_o=01, jump cond=01 addr=0x155 -> branch_o=1, flush_o=1, branch_addr_o=0x155 one cycle; cond=10 -> no branch.
REQ-037 op_en_i=11111 with op_end_i=1 -> HALT, halted_o=1, op_ready_o=0 until rst_i.
REQ-038 rst_i asserted in 2nd VBUSY cycle -> next cycle RUN, vbusy_o=0, flags_q_o=00.
REQ-039 Macro on, MEM_LAT=4, op_valid_i held high across mem op -> stall_cnt_o=3; macro off -> 0.
